// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// BCD_BLANK is the digit code used when BIN_TO_BCD_BLANK_EN is defined.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_BLANK      = 4'hF;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x = x >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5..9 gets +3 so that the
// following left shift carries into the next digit exactly at 10.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  // Accumulator digits never exceed 9, so the sum fits in 4 bits.
  assign d_o = (d_i >= BCD_ADJ_THRESH) ? (d_i + BCD_ADJ_ADD) : d_i;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
// Define BIN_TO_BCD_BLANK_EN to blank leading zero digits (4'hF) in bcd_out.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = clog2(BIN_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_e             state_q;
  logic [BIN_W-1:0]   bin_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;

  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_d;
  logic [BIN_W-1:0]   bin_d;
  logic               shift_out;
  logic               ovf_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (acc_q[4*g +: 4]),
      .d_o (acc_adj[4*g +: 4])
    );
  end

  assign shift_out = acc_adj[ACC_W-1];
  assign acc_d     = {acc_adj[ACC_W-2:0], bin_q[BIN_W-1]};
  assign bin_d     = bin_q << 1;
  assign ovf_d     = ovf_q | shift_out;

  function automatic logic [ACC_W-1:0] fmt_out(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
`ifdef BIN_TO_BCD_BLANK_EN
    logic lead;
    r    = a;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (a[4*i +: 4] == 4'd0)) begin
        r[4*i +: 4] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
`else
    r = a;
`endif
    return r;
  endfunction

  // Outputs are loaded on the edge entering DONE so they are valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            bin_q   <= bin_in;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          bin_q <= bin_d;
          ovf_q <= ovf_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            bcd_out  <= fmt_out(acc_d);
            overflow <= ovf_d;
            done     <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: 3-digit and 2-digit instances.
module tb_bin_to_bcd_seq;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start2;
  logic [7:0]  bin_in, bin2;
  logic        busy, done, ovf;
  logic [11:0] bcd;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;

  int   compared = 0;
  int   failed   = 0;
  exp_t sb[$];
  exp_t last_e;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd), .overflow(ovf)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bin_in(bin2),
    .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2)
  );

  // Decimal reference: digit extraction by division, then optional blanking.
  function automatic exp_t model(input int v, input int digits);
    exp_t e;
    int   q;
    bit   lead;
    e.bcd = '0;
    q = v;
    for (int i = 0; i < digits; i++) begin
      e.bcd[4*i +: 4] = 4'(q % 10);
      q = q / 10;
    end
    e.ovf = (q != 0);
    lead = 1'b1;
`ifdef BIN_TO_BCD_BLANK_EN
    for (int i = digits - 1; i >= 1; i--) begin
      if (lead && e.bcd[4*i +: 4] == 4'd0) e.bcd[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
`endif
    return e;
  endfunction

  // Called at a falling edge with the chosen DUT idle; returns negedges until done.
  task automatic start_conv(input int v, input bit second, output int lat, output bit to);
    sb.push_back(model(v, second ? 2 : 3));
    if (second) begin bin2 = v[7:0]; start2 = 1'b1; end
    else begin bin_in = v[7:0]; start = 1'b1; end
    lat = 0;
    to  = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin start = 1'b0; start2 = 1'b0; end
      if ((second ? done2 : done) === 1'b1) begin lat = n; to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start2 = 1'b0; bin_in = '0; bin2 = '0;
    repeat (3) @(negedge clk);
    compared++;
    if ({busy, done, bcd, ovf} !== 15'd0) begin
      failed++; $display("FAIL reset_dut3 got %h want 0", {busy, done, bcd, ovf});
    end
    compared++;
    if ({busy2, done2, bcd2, ovf2} !== 11'd0) begin
      failed++; $display("FAIL reset_dut2 got %h want 0", {busy2, done2, bcd2, ovf2});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_max();
    int lat; bit to; exp_t e;
    start_conv(255, 1'b0, lat, to);
    compared++;
    if (to || lat != 9) begin
      failed++; $display("FAIL latency255 got %0d want 9 (timeout=%0b)", lat, to);
    end
    e = sb.pop_front(); last_e = e;
    compared++;
    if (bcd !== e.bcd) begin failed++; $display("FAIL bcd255 got %h want %h", bcd, e.bcd); end
    compared++;
    if (ovf !== 1'b0) begin failed++; $display("FAIL ovf255 got %b want 0", ovf); end
    @(negedge clk);
    compared++;
    if ({done, busy} !== 2'b00) begin
      failed++; $display("FAIL done_pulse got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_values();
    int lat; bit to; exp_t e;
    int vals[4];
    vals = '{0, 7, 105, 99};
    foreach (vals[k]) begin
      start_conv(vals[k], 1'b0, lat, to);
      e = sb.pop_front(); last_e = e;
      compared++;
      if (to || bcd !== e.bcd || ovf !== e.ovf) begin
        failed++;
        $display("FAIL value_%0d got bcd=%h ovf=%b want bcd=%h ovf=%b (timeout=%0b)",
                 vals[k], bcd, ovf, e.bcd, e.ovf, to);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_busy_start();
    int dones; exp_t e;
    sb.push_back(model(42, 3));
    bin_in = 8'd42; start = 1'b1;
    dones = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin start = 1'b0; bin_in = 8'd77; end
      if (n == 3) begin start = 1'b1; bin_in = 8'd99; end
      if (n == 4) start = 1'b0;
      if (n == 3) begin
        compared++;
        if (busy !== 1'b1) begin failed++; $display("FAIL busy_mid got %b want 1", busy); end
      end
      if (n == 5) begin
        compared++;
        if (bcd !== last_e.bcd) begin
          failed++; $display("FAIL hold_mid got %h want %h", bcd, last_e.bcd);
        end
      end
      if (done === 1'b1) begin
        dones++;
        if (dones == 1) begin
          e = sb.pop_front(); last_e = e;
          compared++;
          if (bcd !== e.bcd) begin failed++; $display("FAIL bcd42 got %h want %h", bcd, e.bcd); end
        end
      end
    end
    compared++;
    if (dones != 1) begin failed++; $display("FAIL single_done got %0d want 1", dones); end
  endtask

  task automatic test_reset_abort();
    int dones; int lat; bit to; exp_t e;
    bin_in = 8'd200; start = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if ({busy, done, bcd, ovf} !== 15'd0) begin
      failed++; $display("FAIL async_reset got %h want 0", {busy, done, bcd, ovf});
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    compared++;
    if (dones != 0) begin failed++; $display("FAIL no_done_after_abort got %0d want 0", dones); end
    start_conv(13, 1'b0, lat, to);
    e = sb.pop_front(); last_e = e;
    compared++;
    if (to || lat != 9 || bcd !== e.bcd) begin
      failed++; $display("FAIL after_abort got bcd=%h lat=%0d want bcd=%h lat=9", bcd, lat, e.bcd);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow_2digit();
    int lat; bit to; exp_t e;
    int vals[4];
    vals = '{200, 99, 100, 255};
    foreach (vals[k]) begin
      start_conv(vals[k], 1'b1, lat, to);
      e = sb.pop_front();
      compared++;
      if (to || bcd2 !== e.bcd[7:0]) begin
        failed++; $display("FAIL d2_bcd_%0d got %h want %h (timeout=%0b)", vals[k], bcd2, e.bcd[7:0], to);
      end
      compared++;
      if (ovf2 !== e.ovf) begin
        failed++; $display("FAIL d2_ovf_%0d got %b want %b", vals[k], ovf2, e.ovf);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int vals[$]; int n; bit to; exp_t e;
    vals = {1, 2, 3};
    for (int v = 0; v < 256; v++) vals.push_back(v);
    bin_in = vals[0][7:0];
    sb.push_back(model(vals[0], 3));
    start = 1'b1;
    for (int i = 0; i < vals.size(); i++) begin
      n = 0; to = 1'b1;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (done === 1'b1) begin n = k; to = 1'b0; break; end
      end
      if (to) begin
        compared++; failed++;
        $display("FAIL b2b_timeout index %0d got no done want done", i);
        start = 1'b0;
        return;
      end
      if (i > 0) begin
        compared++;
        if (n != 10) begin failed++; $display("FAIL b2b_period idx %0d got %0d want 10", i, n); end
      end
      if (sb.size() == 0) begin
        compared++; failed++;
        $display("FAIL b2b_scoreboard got empty want entry");
      end else begin
        e = sb.pop_front();
        compared++;
        if (bcd !== e.bcd || ovf !== e.ovf) begin
          failed++;
          $display("FAIL b2b_value_%0d got bcd=%h ovf=%b want bcd=%h ovf=%b",
                   vals[i], bcd, ovf, e.bcd, e.ovf);
        end
      end
      if (i + 1 < vals.size()) begin
        bin_in = vals[i+1][7:0];
        sb.push_back(model(vals[i+1], 3));
      end else begin
        start = 1'b0;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_max();
    test_values();
    test_ignore_busy_start();
    test_reset_abort();
    test_overflow_2digit();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
